// File: rtl/alu_control_unit.sv
// ALU control unit: decodes RV32I opcode/funct3/funct7 into a 6-bit ALU
// operation code, registers it into the EX stage and resolves conditional
// branches one cycle later using the ALU zero flag.
//
// Build option: define ALU_CTRL_ILLEGAL_TRAP_EN to flag unsupported
// instructions on the illegal output. Without it, illegal stays 0 and such
// instructions pass through as a plain ADD.
module alu_control_unit (
    input  logic       clk,
    input  logic       reset,
    input  logic       inValid,
    input  logic [6:0] opcode,
    input  logic [2:0] funct3,
    input  logic [6:0] funct7,
    input  logic       stall,
    input  logic       flush,
    input  logic       aluZero,
    output logic [5:0] ALUControl,
    output logic       outValid,
    output logic       isBranch,
    output logic       branchValid,
    output logic       branchTaken,
    output logic       illegal
);

    localparam logic [5:0] OP_AND  = 6'b000000;
    localparam logic [5:0] OP_OR   = 6'b000001;
    localparam logic [5:0] OP_ADD  = 6'b000010;
    localparam logic [5:0] OP_SLL  = 6'b000011;
    localparam logic [5:0] OP_SRL  = 6'b000100;
    localparam logic [5:0] OP_XOR  = 6'b000101;
    localparam logic [5:0] OP_SUB  = 6'b000110;
    localparam logic [5:0] OP_SRA  = 6'b000111;
    localparam logic [5:0] OP_BEQ  = 6'b001000;
    localparam logic [5:0] OP_BNE  = 6'b001001;
    localparam logic [5:0] OP_BLT  = 6'b001010;
    localparam logic [5:0] OP_BGE  = 6'b001011;
    localparam logic [5:0] OP_BLTU = 6'b001100;
    localparam logic [5:0] OP_BGEU = 6'b001101;

    localparam logic [6:0] OPC_R      = 7'b0110011;
    localparam logic [6:0] OPC_I_ALU  = 7'b0010011;
    localparam logic [6:0] OPC_BRANCH = 7'b1100011;
    localparam logic [6:0] OPC_LOAD   = 7'b0000011;
    localparam logic [6:0] OPC_STORE  = 7'b0100011;
    localparam logic [6:0] OPC_LUI    = 7'b0110111;
    localparam logic [6:0] OPC_AUIPC  = 7'b0010111;
    localparam logic [6:0] OPC_JAL    = 7'b1101111;
    localparam logic [6:0] OPC_JALR   = 7'b1100111;

`ifdef ALU_CTRL_ILLEGAL_TRAP_EN
    localparam logic TRAP_EN = 1'b1;
`else
    localparam logic TRAP_EN = 1'b0;
`endif

    // Only funct7[5] distinguishes SUB/SRA; the remaining bits are ignored.
    logic unused_funct7;
    assign unused_funct7 = ^{funct7[6], funct7[4:0]};

    logic [5:0] dec_ctrl;
    logic       dec_branch;
    logic       dec_unsup;

    logic [5:0] alu_ctrl_q,  alu_ctrl_d;
    logic       out_valid_q, out_valid_d;
    logic       is_branch_q, is_branch_d;
    logic       illegal_q,   illegal_d;
    logic       br_valid_q,  br_valid_d;
    logic       br_taken_q,  br_taken_d;

    // Decode the instruction fields into an ALU operation; anything not
    // recognised falls back to ADD and is marked unsupported.
    always_comb begin
        dec_ctrl   = OP_ADD;
        dec_branch = 1'b0;
        dec_unsup  = 1'b0;
        unique case (opcode)
            OPC_R, OPC_I_ALU: begin
                unique case (funct3)
                    3'b000: begin
                        // Immediate form has no SUB; funct7 is part of the imm.
                        if (opcode == OPC_R && funct7[5]) dec_ctrl = OP_SUB;
                        else                              dec_ctrl = OP_ADD;
                    end
                    3'b001: dec_ctrl = OP_SLL;
                    3'b100: dec_ctrl = OP_XOR;
                    3'b101: dec_ctrl = funct7[5] ? OP_SRA : OP_SRL;
                    3'b110: dec_ctrl = OP_OR;
                    3'b111: dec_ctrl = OP_AND;
                    default: begin
                        dec_ctrl  = OP_ADD;
                        dec_unsup = 1'b1;
                    end
                endcase
            end
            OPC_BRANCH: begin
                dec_branch = 1'b1;
                unique case (funct3)
                    3'b000: dec_ctrl = OP_BEQ;
                    3'b001: dec_ctrl = OP_BNE;
                    3'b100: dec_ctrl = OP_BLT;
                    3'b101: dec_ctrl = OP_BGE;
                    3'b110: dec_ctrl = OP_BLTU;
                    3'b111: dec_ctrl = OP_BGEU;
                    default: begin
                        // Unknown branch flavours must never resolve.
                        dec_ctrl   = OP_ADD;
                        dec_branch = 1'b0;
                        dec_unsup  = 1'b1;
                    end
                endcase
            end
            OPC_LOAD, OPC_STORE, OPC_LUI, OPC_AUIPC, OPC_JAL, OPC_JALR: begin
                dec_ctrl = OP_ADD;
            end
            default: begin
                dec_ctrl  = OP_ADD;
                dec_unsup = 1'b1;
            end
        endcase
    end

    // EX-stage next state: flush beats stall beats a new load; a held branch
    // resolves only on a non-stalled, non-flushed edge so it pulses once.
    always_comb begin
        alu_ctrl_d  = alu_ctrl_q;
        out_valid_d = out_valid_q;
        is_branch_d = is_branch_q;
        illegal_d   = illegal_q;
        br_valid_d  = 1'b0;
        br_taken_d  = 1'b0;
        if (flush) begin
            out_valid_d = 1'b0;
            is_branch_d = 1'b0;
            illegal_d   = 1'b0;
        end else if (!stall) begin
            br_valid_d = out_valid_q & is_branch_q;
            br_taken_d = out_valid_q & is_branch_q & aluZero;
            if (inValid) begin
                alu_ctrl_d  = dec_ctrl;
                out_valid_d = 1'b1;
                is_branch_d = dec_branch;
                illegal_d   = TRAP_EN & dec_unsup;
            end else begin
                // ALUControl intentionally keeps its last value to avoid
                // needless toggling of the ALU when the stage is empty.
                out_valid_d = 1'b0;
                is_branch_d = 1'b0;
                illegal_d   = 1'b0;
            end
        end
    end

    // Register the EX stage; reset overrides every other control.
    always_ff @(posedge clk) begin
        if (reset) begin
            alu_ctrl_q  <= OP_ADD;
            out_valid_q <= 1'b0;
            is_branch_q <= 1'b0;
            illegal_q   <= 1'b0;
            br_valid_q  <= 1'b0;
            br_taken_q  <= 1'b0;
        end else begin
            alu_ctrl_q  <= alu_ctrl_d;
            out_valid_q <= out_valid_d;
            is_branch_q <= is_branch_d;
            illegal_q   <= illegal_d;
            br_valid_q  <= br_valid_d;
            br_taken_q  <= br_taken_d;
        end
    end

    assign ALUControl  = alu_ctrl_q;
    assign outValid    = out_valid_q;
    assign isBranch    = is_branch_q;
    assign illegal     = illegal_q;
    assign branchValid = br_valid_q;
    assign branchTaken = br_taken_q;

endmodule

// File: tb/tb_alu_control_unit.sv
// Directed bench for alu_control_unit: a decode vector table plus
// hand-written sequences for branch resolution, stall, flush and reset.
module tb_alu_control_unit;

    logic       clk = 1'b0;
    logic       reset;
    logic       inValid;
    logic [6:0] opcode;
    logic [2:0] funct3;
    logic [6:0] funct7;
    logic       stall;
    logic       flush;
    logic       aluZero;
    logic [5:0] ALUControl;
    logic       outValid;
    logic       isBranch;
    logic       branchValid;
    logic       branchTaken;
    logic       illegal;

`ifdef ALU_CTRL_ILLEGAL_TRAP_EN
    localparam logic TRAP_EN = 1'b1;
`else
    localparam logic TRAP_EN = 1'b0;
`endif

    int n_total = 0;
    int n_pass  = 0;

    alu_control_unit dut (
        .clk        (clk),
        .reset      (reset),
        .inValid    (inValid),
        .opcode     (opcode),
        .funct3     (funct3),
        .funct7     (funct7),
        .stall      (stall),
        .flush      (flush),
        .aluZero    (aluZero),
        .ALUControl (ALUControl),
        .outValid   (outValid),
        .isBranch   (isBranch),
        .branchValid(branchValid),
        .branchTaken(branchTaken),
        .illegal    (illegal)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic       vld;
        logic [6:0] opc;
        logic [2:0] f3;
        logic [6:0] f7;
        logic [5:0] exp_ctrl;
        logic       exp_br;
        logic       unsup;
    } vec_t;

    task automatic check(input string name, input logic [5:0] act, input logic [5:0] exp);
        n_total++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %b expected %b", name, act, exp);
    endtask

    // Advance one clock and sample just after the edge.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic v, input logic [6:0] o, input logic [2:0] f3,
                         input logic [6:0] f7);
        inValid = v;
        opcode  = o;
        funct3  = f3;
        funct7  = f7;
    endtask

    vec_t vecs[$];
    logic prev_br;

    initial begin
        reset = 1'b1; inValid = 1'b1; opcode = 7'b0110011; funct3 = 3'b000;
        funct7 = 7'b0100000; stall = 1'b0; flush = 1'b0; aluZero = 1'b0;

        // Reset held two cycles with a valid SUB on the inputs.
        tick();
        tick();
        check("rst_ctrl",   ALUControl, 6'b000010);
        check("rst_valid",  {5'b0, outValid},    6'd0);
        check("rst_isbr",   {5'b0, isBranch},    6'd0);
        check("rst_bv",     {5'b0, branchValid}, 6'd0);
        check("rst_bt",     {5'b0, branchTaken}, 6'd0);
        check("rst_ill",    {5'b0, illegal},     6'd0);
        reset = 1'b0;
        drive(1'b0, 7'b0, 3'b0, 7'b0);
        tick();

        // Decode table: {valid, opcode, funct3, funct7, ctrl, isBranch, unsupported}
        vecs.push_back('{1, 7'b0110011, 3'b000, 7'b0000000, 6'b000010, 0, 0});
        vecs.push_back('{1, 7'b0110011, 3'b000, 7'b0100000, 6'b000110, 0, 0});
        vecs.push_back('{1, 7'b0110011, 3'b001, 7'b0000000, 6'b000011, 0, 0});
        vecs.push_back('{1, 7'b0110011, 3'b100, 7'b0000000, 6'b000101, 0, 0});
        vecs.push_back('{1, 7'b0110011, 3'b101, 7'b0000000, 6'b000100, 0, 0});
        vecs.push_back('{1, 7'b0110011, 3'b101, 7'b0100000, 6'b000111, 0, 0});
        vecs.push_back('{1, 7'b0110011, 3'b110, 7'b0000000, 6'b000001, 0, 0});
        vecs.push_back('{1, 7'b0110011, 3'b111, 7'b0000000, 6'b000000, 0, 0});
        vecs.push_back('{1, 7'b0010011, 3'b000, 7'b0100000, 6'b000010, 0, 0});
        vecs.push_back('{1, 7'b0010011, 3'b101, 7'b0100000, 6'b000111, 0, 0});
        vecs.push_back('{1, 7'b0010011, 3'b101, 7'b0000000, 6'b000100, 0, 0});
        vecs.push_back('{1, 7'b0010011, 3'b111, 7'b0000000, 6'b000000, 0, 0});
        vecs.push_back('{0, 7'b0110011, 3'b000, 7'b0100000, 6'b000000, 0, 0});
        vecs.push_back('{1, 7'b1100011, 3'b000, 7'b0000000, 6'b001000, 1, 0});
        vecs.push_back('{1, 7'b1100011, 3'b001, 7'b0000000, 6'b001001, 1, 0});
        vecs.push_back('{1, 7'b1100011, 3'b100, 7'b0000000, 6'b001010, 1, 0});
        vecs.push_back('{1, 7'b1100011, 3'b101, 7'b0000000, 6'b001011, 1, 0});
        vecs.push_back('{1, 7'b1100011, 3'b110, 7'b0000000, 6'b001100, 1, 0});
        vecs.push_back('{1, 7'b1100011, 3'b111, 7'b0000000, 6'b001101, 1, 0});
        vecs.push_back('{1, 7'b0000011, 3'b010, 7'b0000000, 6'b000010, 0, 0});
        vecs.push_back('{1, 7'b0100011, 3'b010, 7'b0000000, 6'b000010, 0, 0});
        vecs.push_back('{1, 7'b0110111, 3'b111, 7'b0100000, 6'b000010, 0, 0});
        vecs.push_back('{1, 7'b0010111, 3'b101, 7'b0000000, 6'b000010, 0, 0});
        vecs.push_back('{1, 7'b1101111, 3'b001, 7'b0000000, 6'b000010, 0, 0});
        vecs.push_back('{1, 7'b1100111, 3'b000, 7'b0000000, 6'b000010, 0, 0});
        vecs.push_back('{1, 7'b0110011, 3'b010, 7'b0000000, 6'b000010, 0, 1});
        vecs.push_back('{1, 7'b0010011, 3'b011, 7'b0000000, 6'b000010, 0, 1});
        vecs.push_back('{1, 7'b1100011, 3'b010, 7'b0000000, 6'b000010, 0, 1});
        vecs.push_back('{1, 7'b1110011, 3'b000, 7'b0000000, 6'b000010, 0, 1});
        vecs.push_back('{1, 7'b0001111, 3'b000, 7'b0000000, 6'b000010, 0, 1});

        prev_br = 1'b0;
        foreach (vecs[i]) begin
            drive(vecs[i].vld, vecs[i].opc, vecs[i].f3, vecs[i].f7);
            tick();
            check($sformatf("v%0d_ctrl", i), ALUControl, vecs[i].exp_ctrl);
            check($sformatf("v%0d_valid", i), {5'b0, outValid}, {5'b0, vecs[i].vld});
            check($sformatf("v%0d_isbr", i), {5'b0, isBranch}, {5'b0, vecs[i].exp_br});
            check($sformatf("v%0d_ill", i), {5'b0, illegal},
                  {5'b0, TRAP_EN & vecs[i].unsup});
            check($sformatf("v%0d_bv", i), {5'b0, branchValid}, {5'b0, prev_br});
            check($sformatf("v%0d_bt", i), {5'b0, branchTaken}, 6'd0);
            prev_br = vecs[i].exp_br;
        end
        drive(1'b0, 7'b0, 3'b0, 7'b0);
        tick();

        // inValid=0 keeps ALUControl from the previous SRA.
        drive(1'b1, 7'b0110011, 3'b101, 7'b0100000);
        tick();
        check("sra_ctrl",  ALUControl, 6'b000111);
        check("sra_valid", {5'b0, outValid}, 6'd1);
        drive(1'b0, 7'b0, 3'b0, 7'b0);
        tick();
        check("idle_ctrl",  ALUControl, 6'b000111);
        check("idle_valid", {5'b0, outValid}, 6'd0);

        // BLT taken.
        drive(1'b1, 7'b1100011, 3'b100, 7'b0);
        tick();
        check("blt_ctrl", ALUControl, 6'b001010);
        check("blt_isbr", {5'b0, isBranch}, 6'd1);
        check("blt_bv0",  {5'b0, branchValid}, 6'd0);
        drive(1'b0, 7'b0, 3'b0, 7'b0);
        aluZero = 1'b1;
        tick();
        check("blt_bv",  {5'b0, branchValid}, 6'd1);
        check("blt_bt",  {5'b0, branchTaken}, 6'd1);
        tick();
        check("blt_bv_end", {5'b0, branchValid}, 6'd0);
        check("blt_bt_end", {5'b0, branchTaken}, 6'd0);
        aluZero = 1'b0;

        // BNE stalled for three cycles, resolves once afterwards.
        drive(1'b1, 7'b1100011, 3'b001, 7'b0);
        tick();
        check("bne_ctrl", ALUControl, 6'b001001);
        drive(1'b1, 7'b0110011, 3'b000, 7'b0);
        stall = 1'b1;
        for (int k = 0; k < 3; k++) begin
            tick();
            check($sformatf("stall%0d_ctrl", k), ALUControl, 6'b001001);
            check($sformatf("stall%0d_valid", k), {5'b0, outValid}, 6'd1);
            check($sformatf("stall%0d_isbr", k), {5'b0, isBranch}, 6'd1);
            check($sformatf("stall%0d_bv", k), {5'b0, branchValid}, 6'd0);
        end
        stall = 1'b0;
        drive(1'b0, 7'b0, 3'b0, 7'b0);
        tick();
        check("bne_bv", {5'b0, branchValid}, 6'd1);
        check("bne_bt", {5'b0, branchTaken}, 6'd0);
        tick();
        check("bne_bv_once", {5'b0, branchValid}, 6'd0);

        // Flush together with stall squashes a held BEQ.
        drive(1'b1, 7'b1100011, 3'b000, 7'b0);
        tick();
        check("beq_isbr", {5'b0, isBranch}, 6'd1);
        flush = 1'b1;
        stall = 1'b1;
        aluZero = 1'b1;
        tick();
        check("flush_valid", {5'b0, outValid}, 6'd0);
        check("flush_isbr",  {5'b0, isBranch}, 6'd0);
        check("flush_bv",    {5'b0, branchValid}, 6'd0);
        flush = 1'b0;
        stall = 1'b0;
        drive(1'b0, 7'b0, 3'b0, 7'b0);
        tick();
        check("flush_bv_after", {5'b0, branchValid}, 6'd0);
        tick();
        check("flush_bv_after2", {5'b0, branchValid}, 6'd0);

        // Back-to-back branches each resolve with their own aluZero.
        aluZero = 1'b0;
        drive(1'b1, 7'b1100011, 3'b000, 7'b0);
        tick();
        drive(1'b1, 7'b1100011, 3'b001, 7'b0);
        aluZero = 1'b1;
        tick();
        check("b2b_bv1",  {5'b0, branchValid}, 6'd1);
        check("b2b_bt1",  {5'b0, branchTaken}, 6'd1);
        check("b2b_ctrl", ALUControl, 6'b001001);
        drive(1'b0, 7'b0, 3'b0, 7'b0);
        aluZero = 1'b0;
        tick();
        check("b2b_bv2", {5'b0, branchValid}, 6'd1);
        check("b2b_bt2", {5'b0, branchTaken}, 6'd0);
        tick();
        check("b2b_bv3", {5'b0, branchValid}, 6'd0);

        // Reset with a branch in flight never yields a resolution.
        drive(1'b1, 7'b1100011, 3'b111, 7'b0);
        tick();
        check("rst2_isbr", {5'b0, isBranch}, 6'd1);
        reset = 1'b1;
        aluZero = 1'b1;
        tick();
        check("rst2_ctrl", ALUControl, 6'b000010);
        check("rst2_bv",   {5'b0, branchValid}, 6'd0);
        check("rst2_valid", {5'b0, outValid}, 6'd0);
        reset = 1'b0;
        drive(1'b0, 7'b0, 3'b0, 7'b0);
        tick();
        check("rst2_bv_after", {5'b0, branchValid}, 6'd0);
        check("rst2_bt_after", {5'b0, branchTaken}, 6'd0);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule

// File: doc/alu_control_unit.md
ALU_CONTROL_UNIT -- requirements
Module: alu_control_unit

Interface
REQ-001 SHALL have parameter none; all widths fixed.
REQ-002 clk  input  1  single clock, all state updates on rising edge.
REQ-003 reset  input  1  synchronous, active-high reset.
REQ-004 inValid  input  1  decode-stage instruction fields valid this cycle.
REQ-005 opcode  input  7  RV32I opcode[6:0].
REQ-006 funct3  input  3  instruction funct3.
REQ-007 funct7  input  7  instruction funct7 (only bit 5 used).
REQ-008 stall  input  1  hold all registered state.
REQ-009 flush  input  1  squash the instruction held in the EX register.
REQ-010 aluZero  input  1  zero flag from ALU, combinational from ALUControl of the current cycle.
REQ-011 ALUControl  output  6  registered ALU operation code driving the ALU.
REQ-012 outValid  output  1  ALUControl holds a live instruction.
REQ-013 isBranch  output  1  held instruction is a conditional branch.
REQ-014 branchValid  output  1  one-cycle pulse: branch resolved.
REQ-015 branchTaken  output  1  resolution result, meaningful only while branchValid=1.
REQ-016 illegal  output  1  held instruction is unsupported (see Configuration).

Function
REQ-017 Codes SHALL be: ADD 000010, SUB 000110, AND 000000, OR 000001, SLL 000011, SRL 000100, XOR 000101, SRA 000111, BEQ 001000, BNE 001001, BLT 001010, BGE 001011, BLTU 001100, BGEU 001101.
REQ-018 Opcode 0110011 (R): funct3 000 -> ADD, or SUB if funct7[5]=1; 001 SLL; 100 XOR; 101 SRL, or SRA if funct7[5]=1; 110 OR; 111 AND.
REQ-019 Opcode 0010011 (I-ALU): as REQ-018 except funct3 000 always ADD (funct7 ignored); funct7[5] selects SRA only for funct3 101.
REQ-020 Opcode 1100011 (branch): funct3 000 BEQ, 001 BNE, 100 BLT, 101 BGE, 110 BLTU, 111 BGEU; isBranch=1.
REQ-021 Opcodes 0000011, 0100011, 0110111, 0010111, 1101111, 1100111 SHALL decode to ADD, isBranch=0.
REQ-022 Unsupported combinations (funct3 010/011 under R, I-ALU or branch; any other opcode) SHALL decode to ADD with isBranch=0 and be flagged per REQ-033/034.
REQ-023 Latency: fields sampled at edge E when inValid=1 and stall=0 SHALL appear on ALUControl/outValid/isBranch/illegal after E (1 cycle).
REQ-024 inValid=0 and stall=0 at an edge SHALL load outValid=0, isBranch=0, illegal=0; ALUControl keeps its prior value.
REQ-025 stall=1 and flush=0 SHALL hold ALUControl, outValid, isBranch, illegal unchanged.
REQ-026 Branch resolves at an edge where outValid=1, isBranch=1, stall=0, flush=0: branchValid=1 and branchTaken=aluZero for the following cycle; otherwise branchValid=0, branchTaken=0.
REQ-027 flush=1 SHALL clear outValid, isBranch, illegal at the next edge, suppress resolution, and take priority over stall and inValid.
REQ-028 A stalled branch SHALL resolve exactly once, on the first non-stalled edge.
REQ-029 Back-to-back branches with stall=0 SHALL produce branchValid on consecutive cycles, each with its own aluZero.

Reset
REQ-030 reset=1 at an edge SHALL set ALUControl=000010, outValid=0, isBranch=0, branchValid=0, branchTaken=0, illegal=0.
REQ-031 reset SHALL override stall, flush and inValid; an in-flight branch SHALL never produce branchValid after reset.

Configuration
REQ-032 Macro ALU_CTRL_ILLEGAL_TRAP_EN selects illegal-instruction detection.
REQ-033 Defined: illegal=1 registered with REQ-022 instructions; such instructions SHALL never resolve as branches.
REQ-034 Undefined: illegal tied 0; REQ-022 instructions SHALL pass as plain ADD with outValid=1.

Verification
REQ-035 Reset: reset=1 for 2 cycles with inValid=1 -> all outputs at REQ-030 values, ALUControl=000010.
REQ-036 Decode: opcode 0110011, funct3 101, funct7 0100000, inValid=1 -> next cycle ALUControl=000111, outValid=1, isBranch=0.
REQ-037 Branch: opcode 1100011, funct3 100, then aluZero=1 -> cycle+1 ALUControl=001010, isBranch=1; cycle+2 branchValid=1, branchTaken=1.
REQ-038 Stall: BNE decoded, stall=1 for 3 cycles with aluZero=0 -> ALUControl held at 001001, branchValid=0; one pulse branchValid=1, branchTaken=0 after stall drops.
REQ-039 Flush+stall: BEQ held, flush=1 and stall=1 same cycle -> outValid=0, isBranch=0, branchValid never asserted.
REQ-040 Illegal: opcode 0110011, funct3 010 -> with macro illegal=1, ALUControl=000010; without macro illegal=0, outValid=1.
